inst_fetch_queue: RTL and testbench

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

---
 rtl/inst_fetch_queue.sv | 100 ++++++++++
 tb/tb_inst_fetch_queue.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: 4-wide compacting push, 2-wide in-order pop, circular buffer.
// Latency: a pushed entry is visible on out_* one cycle after its push edge (no bypass).
// Backpressure: in_ready_o drops when fewer than 4 entries are free; upstream holds the packet.
//
// Ports:
//   clk, rst_n          - clock and asynchronous active-low reset
//   flush_i             - drop every queued entry at the next edge
//   in_valid_i/in_data_i- 4-slot fetch packet, valid mask may contain gaps
//   in_ready_o          - at least 4 free entries
//   out_valid_o/out_data_o - two oldest entries, slot 0 is the head
//   pop_num_i           - entries taken by the issue buffer this cycle (0..2)
module inst_fetch_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic [3:0]                 in_valid_i,
  input  logic [3:0][DATA_WIDTH-1:0] in_data_i,
  output logic                       in_ready_o,
  output logic [1:0]                 out_valid_o,
  output logic [1:0][DATA_WIDTH-1:0] out_data_o,
  input  logic [1:0]                 pop_num_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;

  logic [CNT_W-1:0]      free_cnt;
  logic                  do_push;
  logic [2:0]            push_n;
  logic [1:0]            pop_req;
  logic [1:0]            pop_n;
  // Position of each slot among the valid slots: the number of valid slots below it.
  logic [3:0][1:0]       slot_off;

  always_comb begin
    free_cnt   = CNT_W'(DEPTH) - count;
    in_ready_o = (free_cnt >= CNT_W'(4));
    do_push    = in_ready_o && (in_valid_i != 4'b0000);

    push_n = 3'(in_valid_i[0]) + 3'(in_valid_i[1]) + 3'(in_valid_i[2]) + 3'(in_valid_i[3]);

    slot_off[0] = 2'd0;
    slot_off[1] = 2'(in_valid_i[0]);
    slot_off[2] = 2'(in_valid_i[0]) + 2'(in_valid_i[1]);
    slot_off[3] = 2'(in_valid_i[0]) + 2'(in_valid_i[1]) + 2'(in_valid_i[2]);

    // Illegal requests are clamped: 3 behaves as 2, and never pop more than is held.
    pop_req = (pop_num_i == 2'd3) ? 2'd2 : pop_num_i;
    if (CNT_W'(pop_req) > count) begin
      pop_n = count[1:0];  // count is 0 or 1 here
    end else begin
      pop_n = pop_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop_n);
      if (do_push) begin
        tail <= tail + PTR_W'(push_n);
      end
      count <= count + (do_push ? CNT_W'(push_n) : CNT_W'(0)) - CNT_W'(pop_n);
    end
  end

  // Payload storage carries no reset; validity comes from count alone.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) begin
      for (int i = 0; i < 4; i++) begin
        if (in_valid_i[i]) begin
          mem[tail + PTR_W'(slot_off[i])] <= in_data_i[i];
        end
      end
    end
  end

  always_comb begin
    out_valid_o[0] = (count != '0);
    out_valid_o[1] = (count >= CNT_W'(2));
    out_data_o[0]  = mem[head];
    out_data_o[1]  = mem[head + PTR_W'(1)];
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: table of single-cycle vectors plus hand sequences
// for full-queue backpressure, wrap with simultaneous push/pop, flush and async reset.
// Outputs are sampled 1 time unit after the rising edge.
module tb_inst_fetch_queue;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic [3:0]       in_valid;
  logic [3:0][31:0] in_data;
  logic             in_ready;
  logic [1:0]       out_valid;
  logic [1:0][31:0] out_data;
  logic [1:0]       pop_num;

  int checks;
  int failures;
  int mcnt;  // bench's expected occupancy, used to police pop legality

  inst_fetch_queue #(.DATA_WIDTH(32), .DEPTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .in_ready_o (in_ready),
    .out_valid_o(out_valid),
    .out_data_o (out_data),
    .pop_num_i  (pop_num)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (time %0t, required completion)", $time);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  vld;
    logic [31:0] d0, d1, d2, d3;
    logic [1:0]  pop;
    logic [1:0]  e_vld;
    logic [31:0] e_d0, e_d1;
    int          e_cnt;
    logic        e_rdy;
  } vec_t;

  localparam logic [31:0] A  = 32'hA000_00A0, B  = 32'hB000_00B1, C  = 32'hC000_00C2;
  localparam logic [31:0] D  = 32'hD000_00D3, P  = 32'h5000_0050, Q  = 32'h5100_0051;
  localparam logic [31:0] E  = 32'hE000_00E4, P2 = 32'h5200_0052, Q2 = 32'h5300_0053;
  localparam logic [31:0] F  = 32'hF000_00F5, G  = 32'h6600_0066, X  = 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, clock it, and return 1 unit after the edge with inputs idle.
  task automatic step(input logic fl, input logic [3:0] vm,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [31:0] d,
                      input logic [1:0] pn);
    flush    = fl;
    in_valid = vm;
    in_data  = {d, c, b, a};
    pop_num  = pn;
    if (!fl && (pn == 2'd3 || int'(pn) > mcnt)) begin
      failures++;
      $display("FAIL illegal_pop: pop_num %0d with expected count %0d", pn, mcnt);
    end
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 4'b0000;
    pop_num  = 2'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    mcnt = 0;
  endtask

  vec_t vecs[9];

  initial begin
    checks   = 0;
    failures = 0;
    mcnt     = 0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    in_valid = 4'b0000;
    in_data  = '0;
    pop_num  = 2'd0;

    vecs[0] = '{4'b1111, A, B, C, D, 2'd0, 2'b11, A,  B,  4, 1'b1};
    vecs[1] = '{4'b0000, X, X, X, X, 2'd0, 2'b11, A,  B,  4, 1'b1};
    vecs[2] = '{4'b1010, X, P, X, Q, 2'd0, 2'b11, A,  B,  6, 1'b0};
    vecs[3] = '{4'b1111, X, X, X, X, 2'd2, 2'b11, C,  D,  4, 1'b1};
    vecs[4] = '{4'b0001, E, X, X, X, 2'd1, 2'b11, D,  P,  4, 1'b1};
    vecs[5] = '{4'b0000, X, X, X, X, 2'd2, 2'b11, Q,  E,  2, 1'b1};
    vecs[6] = '{4'b0000, X, X, X, X, 2'd2, 2'b00, X,  X,  0, 1'b1};
    vecs[7] = '{4'b1010, X, P2, X, Q2, 2'd0, 2'b11, P2, Q2, 2, 1'b1};
    vecs[8] = '{4'b0101, F, X, G, X, 2'd1, 2'b11, Q2, F,  3, 1'b1};

    do_reset();
    chk("reset_valid", 64'(out_valid), 64'(2'b00));
    chk("reset_ready", 64'(in_ready), 64'(1'b1));
    chk("reset_count", 64'(dut.count), 64'(0));

    for (int i = 0; i < 9; i++) begin
      step(1'b0, vecs[i].vld, vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3, vecs[i].pop);
      chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'(vecs[i].e_vld));
      chk($sformatf("v%0d_count", i), 64'(dut.count), 64'(vecs[i].e_cnt));
      chk($sformatf("v%0d_ready", i), 64'(in_ready), 64'(vecs[i].e_rdy));
      if (vecs[i].e_vld[0]) chk($sformatf("v%0d_d0", i), 64'(out_data[0]), 64'(vecs[i].e_d0));
      if (vecs[i].e_vld[1]) chk($sformatf("v%0d_d1", i), 64'(out_data[1]), 64'(vecs[i].e_d1));
      mcnt = vecs[i].e_cnt;
    end

    // Backpressure at count 5, then release by popping.
    do_reset();
    step(1'b0, 4'b1111, A, B, C, D, 2'd0);        mcnt = 4;
    step(1'b0, 4'b0001, E, X, X, X, 2'd0);        mcnt = 5;
    chk("bp_ready5", 64'(in_ready), 64'(1'b0));
    step(1'b0, 4'b1111, F, F, F, F, 2'd0);
    chk("bp_hold_count", 64'(dut.count), 64'(5));
    chk("bp_hold_tail", 64'(dut.tail), 64'(5));
    step(1'b0, 4'b0000, X, X, X, X, 2'd2);        mcnt = 3;
    chk("bp_pop2_count", 64'(dut.count), 64'(3));
    chk("bp_pop2_ready", 64'(in_ready), 64'(1'b1));
    chk("bp_pop2_d0", 64'(out_data[0]), 64'(C));
    step(1'b0, 4'b0000, X, X, X, X, 2'd1);        mcnt = 2;
    chk("bp_pop1_count", 64'(dut.count), 64'(2));
    chk("bp_pop1_ready", 64'(in_ready), 64'(1'b1));
    chk("bp_pop1_d1", 64'(out_data[1]), 64'(E));

    // Head at entry 6 with 3 entries, then push 4 / pop 2 across the wrap.
    do_reset();
    step(1'b0, 4'b1111, A, B, C, D, 2'd0);        mcnt = 4;
    step(1'b0, 4'b0011, E, F, X, X, 2'd2);        mcnt = 4;
    step(1'b0, 4'b0000, X, X, X, X, 2'd2);        mcnt = 2;
    step(1'b0, 4'b0000, X, X, X, X, 2'd2);        mcnt = 0;
    step(1'b0, 4'b0111, P, Q, G, X, 2'd0);        mcnt = 3;
    chk("wrap_pre_head", 64'(dut.head), 64'(6));
    chk("wrap_pre_tail", 64'(dut.tail), 64'(1));
    step(1'b0, 4'b1111, P2, Q2, B, C, 2'd2);      mcnt = 5;
    chk("wrap_count", 64'(dut.count), 64'(5));
    chk("wrap_head", 64'(dut.head), 64'(0));
    chk("wrap_tail", 64'(dut.tail), 64'(5));
    chk("wrap_d0", 64'(out_data[0]), 64'(G));
    chk("wrap_d1", 64'(out_data[1]), 64'(P2));

    // Flush with a same-cycle push and pop.
    do_reset();
    step(1'b0, 4'b1111, A, B, C, D, 2'd0);        mcnt = 4;
    step(1'b0, 4'b0011, E, F, X, X, 2'd0);        mcnt = 6;
    step(1'b1, 4'b1111, P, Q, G, X, 2'd2);        mcnt = 0;
    chk("flush_count", 64'(dut.count), 64'(0));
    chk("flush_valid", 64'(out_valid), 64'(2'b00));
    chk("flush_head", 64'(dut.head), 64'(0));
    chk("flush_tail", 64'(dut.tail), 64'(0));
    chk("flush_ready", 64'(in_ready), 64'(1'b1));
    step(1'b0, 4'b0100, X, X, Q2, X, 2'd0);       mcnt = 1;
    chk("flush_push_valid", 64'(out_valid), 64'(2'b01));
    chk("flush_push_d0", 64'(out_data[0]), 64'(Q2));

    // Asynchronous reset mid-cycle with 7 entries held.
    do_reset();
    step(1'b0, 4'b1111, A, B, C, D, 2'd0);        mcnt = 4;
    step(1'b0, 4'b0111, E, F, G, X, 2'd0);        mcnt = 7;
    chk("arst_pre_count", 64'(dut.count), 64'(7));
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'(2'b00));
    chk("arst_ready", 64'(in_ready), 64'(1'b1));
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    mcnt = 0;
    step(1'b0, 4'b0010, X, P, X, X, 2'd0);        mcnt = 1;
    chk("arst_push_valid", 64'(out_valid), 64'(2'b01));
    chk("arst_push_d0", 64'(out_data[0]), 64'(P));
    chk("arst_push_head", 64'(dut.head), 64'(0));
    chk("arst_push_tail", 64'(dut.tail), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
